// File: rtl/led_pkg.sv
// Shared mode encodings and step-period helper for the LED pattern generator.
// Pure constants and functions; no clocked logic.
package led_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Clock cycles per base pattern step at SPEED=0.
    function automatic int step_cycles(input int clock_freq, input int step_ms);
        return clock_freq / 1000 * step_ms;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Prescaler: tick is combinational in the cycle the count reaches limit-1; count wraps on the next edge.
// pause freezes the count and masks tick; clear zeroes the count and masks tick.
module step_tick_gen #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CNT_W-1:0] limit,
    input  logic             pause,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    // Using >= lets a shrinking limit fire on the next cycle instead of waiting for a full wrap.
    assign at_end = (cnt >= (limit - CNT_W'(1)));
    assign tick   = at_end && !pause && !clear;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!pause) begin
            cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator (rotate L/R, bounce, blink; breathing in mode 3 when LED_BREATH_EN is defined).
// LED/STEP_PULSE registered, one cycle after the prescaler tick; PAUSE freezes prescaler and pattern.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LED_NUM    = 4,
    parameter int CLOCK_FREQ = 50000000,
    parameter int STEP_MS    = 500,
    parameter int PWM_BITS   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         MODE,
    input  logic [1:0]         SPEED,
    input  logic               PAUSE,
    output logic [LED_NUM-1:0] LED,
    output logic               STEP_PULSE
);

    localparam int STEP_CYCLES = step_cycles(CLOCK_FREQ, STEP_MS);
    localparam int CNT_W       = $clog2(STEP_CYCLES + 1);
    localparam int IDX_W       = $clog2(LED_NUM);

    if (LED_NUM < 2 || PWM_BITS < 1) begin : g_param_check
        $error("led_pattern_gen: LED_NUM must be >= 2 and PWM_BITS >= 1");
    end

    logic [CNT_W-1:0] limit_raw;
    logic [CNT_W-1:0] limit;
    logic             tick;
    logic             reload;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             dir_down;
    logic             dir_nxt;

    always_comb begin
        limit_raw = CNT_W'(STEP_CYCLES) >> SPEED;
        limit     = (limit_raw == '0) ? CNT_W'(1) : limit_raw;
    end

    assign reload = (MODE != mode_q);

    step_tick_gen #(.CNT_W(CNT_W)) u_step_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .limit (limit),
        .pause (PAUSE),
        .clear (reload),
        .tick  (tick)
    );

    // Bounce turns around at the ends without repeating the end LED.
    always_comb begin
        idx_nxt = idx;
        dir_nxt = dir_down;
        if (!dir_down) begin
            if (idx == IDX_W'(LED_NUM - 1)) begin
                idx_nxt = idx - IDX_W'(1);
                dir_nxt = 1'b1;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end else begin
            if (idx == '0) begin
                idx_nxt = IDX_W'(1);
                dir_nxt = 1'b0;
            end else begin
                idx_nxt = idx - IDX_W'(1);
            end
        end
    end

`ifdef LED_BREATH_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    logic [CNT_W-1:0]    sub_raw;
    logic [CNT_W-1:0]    sub_limit;
    logic                sub_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                duty_down;

    always_comb begin
        sub_raw   = limit >> PWM_BITS;
        sub_limit = (sub_raw == '0) ? CNT_W'(1) : sub_raw;
    end

    step_tick_gen #(.CNT_W(CNT_W)) u_breath_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .limit (sub_limit),
        .pause (PAUSE),
        .clear (reload),
        .tick  (sub_tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED        <= LED_NUM'(1);
            STEP_PULSE <= 1'b0;
            mode_q     <= MODE_ROT_L;
            idx        <= '0;
            dir_down   <= 1'b0;
`ifdef LED_BREATH_EN
            duty       <= '0;
            duty_down  <= 1'b0;
`endif
        end else begin
            STEP_PULSE <= 1'b0;
            if (reload) begin
                mode_q   <= MODE;
                idx      <= '0;
                dir_down <= 1'b0;
`ifdef LED_BREATH_EN
                duty      <= '0;
                duty_down <= 1'b0;
`endif
                case (MODE)
                    MODE_ROT_R: LED <= {1'b1, {(LED_NUM-1){1'b0}}};
                    MODE_BLINK: LED <= '1;
                    default:    LED <= LED_NUM'(1);
                endcase
            end
`ifdef LED_BREATH_EN
            else if (mode_q == MODE_BLINK) begin
                LED <= {LED_NUM{(pwm_cnt < duty)}};
                if (sub_tick) begin
                    if (!duty_down) begin
                        duty <= duty + PWM_BITS'(1);
                        if (duty == DUTY_MAX - PWM_BITS'(1)) begin
                            duty_down  <= 1'b1;
                            STEP_PULSE <= 1'b1;
                        end
                    end else begin
                        duty <= duty - PWM_BITS'(1);
                        if (duty == PWM_BITS'(1)) begin
                            duty_down  <= 1'b0;
                            STEP_PULSE <= 1'b1;
                        end
                    end
                end
            end
`endif
            else if (tick) begin
                STEP_PULSE <= 1'b1;
                case (mode_q)
                    MODE_ROT_L: LED <= {LED[LED_NUM-2:0], LED[LED_NUM-1]};
                    MODE_ROT_R: LED <= {LED[0], LED[LED_NUM-1:1]};
                    MODE_BOUNCE: begin
                        idx      <= idx_nxt;
                        dir_down <= dir_nxt;
                        LED      <= LED_NUM'(1) << idx_nxt;
                    end
                    default:    LED <= ~LED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with STEP_CYCLES=8, LED_NUM=4.
// Reference model tracks step count per mode and derives the LED pattern arithmetically.
module tb_led_pattern_gen;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] MODE;
    logic [1:0] SPEED;
    logic       PAUSE;
    logic [3:0] LED;
    logic       STEP_PULSE;

    int total = 0;
    int bad   = 0;

    int   m_mode;
    int   m_cnt;
    int   m_step;
    logic m_pulse;

    logic [3:0] saved_led;
    logic [3:0] t1_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] t2_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    led_pattern_gen #(
        .LED_NUM    (4),
        .CLOCK_FREQ (1000),
        .STEP_MS    (8),
        .PWM_BITS   (8)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MODE       (MODE),
        .SPEED      (SPEED),
        .PAUSE      (PAUSE),
        .LED        (LED),
        .STEP_PULSE (STEP_PULSE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_cnt   = 0;
        m_step  = 0;
        m_pulse = 1'b0;
    endtask

    // Expected LED purely from mode and number of steps since the mode was entered.
    function automatic logic [3:0] model_led();
        int p;
        case (m_mode)
            0: return 4'(1 << (m_step % 4));
            1: return 4'(8 >> (m_step % 4));
            2: begin
                p = m_step % 6;
                return 4'(1 << ((p < 4) ? p : 6 - p));
            end
            default: return ((m_step % 2) == 0) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic model_edge();
        int lim;
        if (int'(MODE) != m_mode) begin
            m_mode  = int'(MODE);
            m_cnt   = 0;
            m_step  = 0;
            m_pulse = 1'b0;
        end else if (PAUSE) begin
            m_pulse = 1'b0;
        end else begin
            lim = 8 >> SPEED;
            if (lim < 1) lim = 1;
            if (m_cnt >= lim - 1) begin
                m_cnt   = 0;
                m_step++;
                m_pulse = 1'b1;
            end else begin
                m_cnt++;
                m_pulse = 1'b0;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        chk({tag, ".led"}, 32'(LED), 32'(model_led()));
        chk({tag, ".pulse"}, 32'(STEP_PULSE), 32'(m_pulse));
    endtask

    initial begin
        RST_N = 1'b1;
        MODE  = 2'd0;
        SPEED = 2'd0;
        PAUSE = 1'b0;
        #1 RST_N = 1'b0;
        #2;
        chk("reset.led", 32'(LED), 32'h1);
        chk("reset.pulse", 32'(STEP_PULSE), 32'h0);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        model_reset();

        // 1: rotate left, one step every 8 cycles
        for (int i = 1; i <= 32; i++) begin
            step("t1");
            if (i % 8 == 0) begin
                chk("t1.seq", 32'(LED), 32'(t1_exp[(i / 8) - 1]));
                chk("t1.strobe", 32'(STEP_PULSE), 32'h1);
            end
        end

        // 2: bounce, no repeated end value
        MODE = 2'd2;
        step("t2.reload");
        chk("t2.init", 32'(LED), 32'h1);
        for (int i = 1; i <= 56; i++) begin
            step("t2");
            if (i % 8 == 0) chk("t2.seq", 32'(LED), 32'(t2_exp[(i / 8) - 1]));
        end

        // 3: switch rotate-right to blink at CNT=5
        MODE = 2'd1;
        step("t3.reload_r");
        chk("t3.init_r", 32'(LED), 32'h8);
        for (int k = 0; k < 20 && m_cnt != 5; k++) step("t3.wait");
        chk("t3.reach_cnt5", 32'(m_cnt), 32'd5);
        MODE = 2'd3;
        step("t3.reload_b");
        chk("t3.blink_init", 32'(LED), 32'hF);
        chk("t3.no_pulse", 32'(STEP_PULSE), 32'h0);
        for (int i = 1; i <= 8; i++) step("t3");
        chk("t3.blink_off", 32'(LED), 32'h0);
        chk("t3.blink_pulse", 32'(STEP_PULSE), 32'h1);

        // 4: fastest speed, then shrink period mid-count
        MODE = 2'd0;
        step("t4.reload");
        SPEED = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step("t4.fast");
            chk("t4.fast_pulse", 32'(STEP_PULSE), 32'h1);
        end
        SPEED = 2'd0;
        for (int k = 0; k < 20 && m_cnt != 5; k++) step("t4.wait");
        chk("t4.reach_cnt5", 32'(m_cnt), 32'd5);
        SPEED = 2'd2;
        step("t4.shrink");
        chk("t4.shrink_pulse", 32'(STEP_PULSE), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("t4.div2");
            chk("t4.div2_pulse", 32'(STEP_PULSE), 32'((i % 2) == 1));
        end

        // 5: pause at CNT=3 holds everything, resumes from held count
        SPEED = 2'd0;
        for (int k = 0; k < 20 && m_cnt != 3; k++) step("t5.wait");
        chk("t5.reach_cnt3", 32'(m_cnt), 32'd3);
        saved_led = LED;
        PAUSE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("t5.paused");
            chk("t5.hold_led", 32'(LED), 32'(saved_led));
            chk("t5.hold_pulse", 32'(STEP_PULSE), 32'h0);
        end
        PAUSE = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step("t5.resume");
            chk("t5.resume_pulse", 32'(STEP_PULSE), 32'(i == 5));
        end

        // 6: async reset while bouncing downward through idx 2
        MODE = 2'd2;
        step("t6.reload");
        for (int k = 0; k < 100 && !((m_step % 6) == 4 && m_cnt == 3); k++) step("t6.wait");
        chk("t6.descending", 32'(LED), 32'h4);
        #3 RST_N = 1'b0;
        #1;
        chk("t6.async_led", 32'(LED), 32'h1);
        chk("t6.async_pulse", 32'(STEP_PULSE), 32'h0);
        model_reset();
        @(posedge CLK);
        #2 RST_N = 1'b1;
        step("t6.reload_after_rst");
        for (int i = 1; i <= 8; i++) step("t6.up");
        chk("t6.dir_up", 32'(LED), 32'h2);

        // Random mix of mode, speed and pause changes
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) SPEED = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) PAUSE = ~PAUSE;
            step("rnd");
        end
        PAUSE = 1'b0;
        for (int i = 0; i < 16; i++) step("rnd.tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
